// File: rtl/clksw_pkg.sv
// Shared types and constants for the clk_cog switch controller.
// Optional lock-timeout/FAULT support is enabled with CLKSW_TIMEOUT_EN.
package clksw_pkg;

    localparam int CNT_W       = 16;
    localparam int CFG_W       = 7;
    localparam int CFG_PLLENA  = 6;
    localparam int CFG_OSCENA  = 5;
    localparam int CFG_OSCM_HI = 4;
    localparam int CFG_OSCM_LO = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_APPLY,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_UNGATE
`ifdef CLKSW_TIMEOUT_EN
        , ST_FAULT
`endif
    } clksw_state_e;

    // A relock is only worth waiting for if the PLL ends up enabled and any
    // oscillator/PLL field actually moved.
    function automatic logic needs_relock(input logic [CFG_W-1:0] cfg_new,
                                          input logic [CFG_W-1:0] cfg_old);
        return cfg_new[CFG_PLLENA] &&
               (cfg_new[CFG_PLLENA:CFG_OSCM_LO] != cfg_old[CFG_PLLENA:CFG_OSCM_LO]);
    endfunction

endpackage

// File: rtl/clksw_cnt.sv
// Loadable 16-bit down-counter that saturates at zero; zero flag is combinational.
module clksw_cnt
    import clksw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Gated clock-config switch: gate clk_cog, apply config, optionally wait for PLL lock, settle, ungate.
// Define CLKSW_TIMEOUT_EN to add the lock timeout, FAULT rollback and sticky lock_err.
module clk_switch_ctrl
    import clksw_pkg::*;
#(
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic             clock_160,
    input  logic             res,
    input  logic [CFG_W-1:0] cfg_req,
    input  logic             pll_locked,
    output logic [CFG_W-1:0] cfg_applied,
    output logic             clk_en,
    output logic             busy,
    output logic             lock_err
);

    if (GATE_CYCLES < 1 || GATE_CYCLES > 255) begin : g_gate_range
        $error("GATE_CYCLES out of range 1..255");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_range
        $error("SETTLE_CYCLES out of range 1..255");
    end
    if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_timeout_range
        $error("LOCK_TIMEOUT out of range 2..65535");
    end

    clksw_state_e     state, state_nx;
    logic [CFG_W-1:0] cfg_new, cfg_old;
    logic             latch_req, do_apply;
    logic             gate_load, gate_zero;
    logic             settle_load, settle_zero;
`ifdef CLKSW_TIMEOUT_EN
    logic             to_load, to_zero, do_fault;
`endif

    always_ff @(posedge clock_160) begin
        if (res) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        latch_req   = 1'b0;
        do_apply    = 1'b0;
        gate_load   = 1'b0;
        settle_load = 1'b0;
`ifdef CLKSW_TIMEOUT_EN
        to_load     = 1'b0;
        do_fault    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (cfg_req != cfg_applied) begin
                    state_nx  = ST_GATE;
                    latch_req = 1'b1;
                    gate_load = 1'b1;
                end
            end
            ST_GATE: begin
                if (gate_zero) state_nx = ST_APPLY;
            end
            ST_APPLY: begin
                do_apply = 1'b1;
                if (needs_relock(cfg_new, cfg_old)) begin
                    state_nx = ST_WAIT_LOCK;
`ifdef CLKSW_TIMEOUT_EN
                    to_load  = 1'b1;
`endif
                end else begin
                    state_nx    = ST_SETTLE;
                    settle_load = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout expiring in the same cycle.
                if (pll_locked) begin
                    state_nx    = ST_SETTLE;
                    settle_load = 1'b1;
                end
`ifdef CLKSW_TIMEOUT_EN
                else if (to_zero) begin
                    state_nx = ST_FAULT;
                end
`endif
            end
            ST_SETTLE: begin
                if (settle_zero) state_nx = ST_UNGATE;
            end
            ST_UNGATE: begin
                state_nx = ST_IDLE;
            end
`ifdef CLKSW_TIMEOUT_EN
            ST_FAULT: begin
                do_fault    = 1'b1;
                state_nx    = ST_SETTLE;
                settle_load = 1'b1;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    // clk_en comes straight from a flop so the cog clock gate never sees a glitch.
    always_ff @(posedge clock_160) begin
        if (res) begin
            cfg_new     <= '0;
            cfg_old     <= '0;
            cfg_applied <= '0;
            clk_en      <= 1'b1;
        end else begin
            if (latch_req) begin
                cfg_new <= cfg_req;
                cfg_old <= cfg_applied;
            end
            if (do_apply) cfg_applied <= cfg_new;
`ifdef CLKSW_TIMEOUT_EN
            if (do_fault) cfg_applied <= cfg_old;
`endif
            clk_en <= (state_nx == ST_IDLE) || (state_nx == ST_UNGATE);
        end
    end

    assign busy = (state != ST_IDLE);

    // GATE sees the loaded value down to and including zero; SETTLE is loaded one short
    // so it lasts exactly SETTLE_CYCLES.
    clksw_cnt u_gate_cnt (
        .clk      (clock_160),
        .rst      (res),
        .load     (gate_load),
        .load_val (CNT_W'(GATE_CYCLES)),
        .dec      (state == ST_GATE),
        .zero     (gate_zero)
    );

    clksw_cnt u_settle_cnt (
        .clk      (clock_160),
        .rst      (res),
        .load     (settle_load),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (state == ST_SETTLE),
        .zero     (settle_zero)
    );

`ifdef CLKSW_TIMEOUT_EN
    clksw_cnt u_timeout_cnt (
        .clk      (clock_160),
        .rst      (res),
        .load     (to_load),
        .load_val (CNT_W'(LOCK_TIMEOUT - 1)),
        .dec      (state == ST_WAIT_LOCK),
        .zero     (to_zero)
    );

    always_ff @(posedge clock_160) begin
        if (res)           lock_err <= 1'b0;
        else if (do_fault) lock_err <= 1'b1;
    end
`else
    assign lock_err = 1'b0;
`endif

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 4: clk_en-low cycles before the new config is applied (range 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles held after lock, or after apply when no relock is needed (range 1..255).
REQ-003 Parameter LOCK_TIMEOUT, default 1024: maximum WAIT_LOCK cycles, used only when CLKSW_TIMEOUT_EN is defined (range 2..65535).
REQ-004 The block SHALL have one clock, clock_160, and one reset, res, which is synchronous and active-high.
REQ-005 clock_160  in  1  system clock; all logic on the rising edge.
REQ-006 res  in  1  synchronous active-high reset.
REQ-007 cfg_req  in  7  requested clock config: [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
REQ-008 pll_locked  in  1  PLL lock status, already synchronous to clock_160.
REQ-009 cfg_applied  out  7  config driven to the clock generator.
REQ-010 clk_en  out  1  cog clock enable; 0 gates clk_cog.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 lock_err  out  1  sticky lock-timeout flag.

Function
REQ-013 States SHALL be IDLE, GATE, APPLY, WAIT_LOCK, SETTLE, UNGATE, and FAULT when CLKSW_TIMEOUT_EN is defined.
REQ-014 IDLE SHALL go to GATE on the next edge when cfg_req != cfg_applied, latching cfg_req into cfg_new and cfg_applied into cfg_old.
REQ-015 Entering GATE SHALL drive clk_en=0 and load a down-counter with GATE_CYCLES; the counter decrements each cycle, and the FSM goes to APPLY when it reaches 0.
REQ-016 APPLY SHALL last exactly one cycle and write cfg_applied <= cfg_new.
REQ-017 From APPLY, the FSM SHALL go to WAIT_LOCK if cfg_new[6:3] != cfg_old[6:3] and cfg_new[6]=1; otherwise to SETTLE.
REQ-018 WAIT_LOCK SHALL go to SETTLE on the first cycle pll_locked=1, including if it is already high on entry.
REQ-019 SETTLE SHALL count SETTLE_CYCLES and then go to UNGATE.
REQ-020 UNGATE SHALL set clk_en=1 for one cycle and then go to IDLE.
REQ-021 Gate-to-ungate latency SHALL be GATE_CYCLES+1+SETTLE_CYCLES+1 cycles, plus WAIT_LOCK cycles when relocking.
REQ-022 cfg_req changes while busy SHALL be ignored, and cfg_new is held; the next request is detected only in IDLE, earliest one cycle after UNGATE.
REQ-023 A cfg_req equal to cfg_applied in IDLE SHALL produce no sequence: clk_en stays 1 and busy stays 0.
REQ-024 pll_locked falling outside WAIT_LOCK SHALL be ignored.
REQ-025 Counters SHALL be 16 bits wide, saturate at 0, and never wrap.

Reset
REQ-026 res=1 SHALL force, on the next edge: state=IDLE, cfg_applied=7'h00, clk_en=1, busy=0, lock_err=0, all counters 0; this includes reset asserted mid-sequence.
REQ-027 res SHALL take priority over every FSM transition in the same cycle.

Configuration
REQ-028 With CLKSW_TIMEOUT_EN defined, WAIT_LOCK SHALL count cycles, and when the count reaches LOCK_TIMEOUT without lock, go to FAULT.
REQ-029 FAULT SHALL last one cycle: set cfg_applied <= cfg_old, set lock_err=1, then go to SETTLE so that clk_en returns to 1 via UNGATE.
REQ-030 lock_err SHALL clear only on res.
REQ-031 Without CLKSW_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, FAULT and its counter SHALL not exist, and lock_err SHALL be tied 0.

Structure
REQ-032 A shared package clksw_pkg SHALL hold the state enum typedef, the cfg bit-field index constants (PLLENA=6, OSCENA=5, OSCM_HI=4, OSCM_LO=3) and the 16-bit counter width.
REQ-033 One sub-module, clksw_cnt (a loadable saturating down-counter with zero flag), SHALL be instantiated for the gate, settle and timeout counts; the rest of the FSM SHALL stay in clk_switch_ctrl.

Verification
REQ-034 Reset: res=1 for 2 cycles mid-WAIT_LOCK -> next cycle cfg_applied=00, clk_en=1, busy=0, lock_err=0.
REQ-035 CLKSEL-only change: 00->02 with defaults -> clk_en low for exactly 22 cycles, cfg_applied=02 one cycle after GATE ends, no WAIT_LOCK.
REQ-036 PLL change: 00->6A, pll_locked rises 50 cycles after APPLY -> clk_en low for 22+50 cycles, busy falls the cycle after clk_en rises.
REQ-037 Request during busy: cfg_req 02->03 in GATE -> the first sequence applies 02, then a second sequence starts one cycle after IDLE and applies 03.
REQ-038 Timeout (CLKSW_TIMEOUT_EN, LOCK_TIMEOUT=8): 00->6A, pll_locked=0 -> FAULT after 8 WAIT_LOCK cycles, cfg_applied back to 00, lock_err=1, clk_en=1 after SETTLE.
REQ-039 No-op: cfg_req=cfg_applied=05 held 100 cycles -> busy=0 and clk_en=1 throughout.
